// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with a per-register pending-write (busy) bit for RAW hazard detection.
// Optional macro REGFILE_BYPASS_EN: write-first forwarding of a same-edge write into the read ports.
module regfile_mp_scoreboard #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2,
   parameter int ZERO_REG   = 1
) (
   input  logic                           clock,
   input  logic                           resetN,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] rdAddr,
   output logic [NUM_READ*DATA_WIDTH-1:0] rdData,
   output logic [NUM_READ-1:0]            rdBusy,
   input  logic                           wrEn,
   input  logic [ADDR_WIDTH-1:0]          wrAddr,
   input  logic [DATA_WIDTH-1:0]          wrData,
   input  logic                           busySet,
   input  logic [ADDR_WIDTH-1:0]          busySetAddr
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
   localparam logic HAS_ZERO = (ZERO_REG != 0);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [DEPTH-1:0]      busy_r;
   logic [DEPTH-1:0]      busy_next_s;
   logic                  wr_ok_s;
   logic                  bs_ok_s;
   logic [DATA_WIDTH-1:0] rd_data_s [NUM_READ];
   logic                  rd_busy_s [NUM_READ];

   // A hardwired zero register swallows both writes and busy marks
   assign wr_ok_s = wrEn    & ~(HAS_ZERO & (wrAddr      == ADDR_ZERO));
   assign bs_ok_s = busySet & ~(HAS_ZERO & (busySetAddr == ADDR_ZERO));

   // Next busy vector: a busy set beats a write-back clear to the same register
   always_comb begin
      busy_next_s = busy_r;
      for (int i = 0; i < DEPTH; i++) begin
         if (bs_ok_s && (busySetAddr == ADDR_WIDTH'(i))) begin
            busy_next_s[i] = 1'b1;
         end else if (wr_ok_s && (wrAddr == ADDR_WIDTH'(i))) begin
            busy_next_s[i] = 1'b0;
         end else begin
            busy_next_s[i] = busy_r[i];
         end
      end
   end

   // Register storage
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (wr_ok_s) begin
         mem_r[wrAddr] <= wrData;
      end
   end

   // Busy bit storage
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         busy_r <= '0;
      end else begin
         busy_r <= busy_next_s;
      end
   end

   for (genvar k = 0; k < NUM_READ; k++) begin : g_port
      logic [ADDR_WIDTH-1:0] addr_s;
      assign addr_s = rdAddr[k*ADDR_WIDTH +: ADDR_WIDTH];

      // Read source select: zero register, forwarded write, or stored state
      always_comb begin
         if (HAS_ZERO && (addr_s == ADDR_ZERO)) begin
            rd_data_s[k] = '0;
            rd_busy_s[k] = 1'b0;
`ifdef REGFILE_BYPASS_EN
         end else if (wr_ok_s && (wrAddr == addr_s)) begin
            rd_data_s[k] = wrData;
            rd_busy_s[k] = bs_ok_s && (busySetAddr == addr_s);
`endif
         end else begin
            rd_data_s[k] = mem_r[addr_s];
            rd_busy_s[k] = busy_r[addr_s];
         end
      end
   end

   // Registered read ports
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         rdData <= '0;
         rdBusy <= '0;
      end else begin
         for (int k = 0; k < NUM_READ; k++) begin
            rdData[k*DATA_WIDTH +: DATA_WIDTH] <= rd_data_s[k];
            rdBusy[k]                          <= rd_busy_s[k];
         end
      end
   end

endmodule
